stopwatch_display_ctrl: RTL

Consumer end of the stopwatch tick path: takes the 1 ms count tick (`tc_cnt`) and the display-refresh tick (`tc_led`) from the clock divider and turns them into a running SS.cc time and a multiplexed 4-digit 7-segment drive. It holds the run/pause/lap/clear state machine driven by two pre-debounced button pulses. It sits between the clock divider and the board's seven-segment pins.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 22 ++
 rtl/stopwatch_display_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, segment patterns and BCD time increment
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic c1, c2, c3;
    c1 = t[3:0] == 4'd9;
    c2 = c1 && t[7:4] == 4'd9;
    c3 = c2 && t[11:8] == 4'd9;
    bcd_inc[3:0] = c1 ? 4'd0 : t[3:0] + 4'd1;
    bcd_inc[7:4] = c2 ? 4'd0 : c1 ? t[7:4] + 4'd1 : t[7:4];
    bcd_inc[11:8] = c3 ? 4'd0 : c2 ? t[11:8] + 4'd1 : t[11:8];
    bcd_inc[15:12] = (c3 && t[15:12] == 4'd5) ? 4'd0 : c3 ? t[15:12] + 4'd1 : t[15:12];
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a} pattern, blank above 9
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
endmodule

// File: rtl/stopwatch_display_ctrl.sv
// stopwatch_display_ctrl: run/pause/lap stopwatch with SS.cc time on a scanned 4-digit display
module stopwatch_display_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MS_PER_CS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tc_cnt,
  input  logic                  tc_led,
  input  logic                  btn_start,
  input  logic                  btn_lap,
  output logic                  running,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int PW = $clog2(MS_PER_CS);
  state_t state;
  logic [PW-1:0] ps;
  logic [15:0] t, lap_t, shown;
  logic [1:0] idx;
  logic counting, tick;
  logic [3:0] digit;
  logic [6:0] pat;
  assign counting = state == RUN || state == LAP;
  assign tick = counting && tc_cnt && ps == PW'(MS_PER_CS - 1);
  assign shown = state == LAP ? lap_t : t;
  assign digit = shown[{idx, 2'b00} +: 4];
  bcd_to_seg7 u_dec (.bcd(digit), .seg(pat));
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      ps <= '0;
      t <= '0;
      lap_t <= '0;
      idx <= '0;
      running <= 1'b0;
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
    end else begin
      running <= counting;
      an <= ~(4'b0001 << idx);
      seg <= pat;
      dp <= idx != 2'd2;
      if (tc_led) idx <= idx + 2'd1;
      if (counting && tc_cnt) ps <= tick ? '0 : ps + 1'b1;
      if (tick) t <= bcd_inc(t);
      if (btn_start) state <= counting ? PAUSE : RUN;
      else if (btn_lap) begin
        if (state == RUN) begin
          state <= LAP;
          lap_t <= t;
        end else if (state == LAP) state <= RUN;
        else if (state == PAUSE) begin
          state <= IDLE;
          ps <= '0;
          t <= '0;
        end
      end
    end
endmodule
